// File: rtl/mmio_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module  : mmio_bus_bridge
// Purpose : CPU-to-peripheral MMIO bridge (setup/access handshake) with wait
//           states, bus timeout and unmapped-region error responses.
// Rev     : 1.0 - initial release
// ============================================================================
module mmio_bus_bridge #(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       N_PERIPH       = 4,
    parameter int unsigned       WINDOW_REGIONS = 8,
    parameter logic [ADDR_W-1:0] MMIO_BASE      = 32'hFFFF0000,
    parameter int unsigned       REGION_SHIFT   = 3,
    parameter int unsigned       TIMEOUT        = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_req_i,
    input  logic                         cpu_write_i,
    input  logic [ADDR_W-1:0]            cpu_addr_i,
    input  logic [DATA_W-1:0]            cpu_wdata_i,
    output logic [DATA_W-1:0]            cpu_rdata_o,
    output logic                         cpu_stall_o,
    output logic                         cpu_done_o,
    output logic                         cpu_err_o,
    output logic                         mem_sel_o,
    output logic [N_PERIPH-1:0]          p_sel_o,
    output logic                         p_enable_o,
    output logic                         p_write_o,
    output logic [REGION_SHIFT-1:0]      p_addr_o,
    output logic [DATA_W-1:0]            p_wdata_o,
    input  logic [N_PERIPH*DATA_W-1:0]   p_rdata_i,
    input  logic [N_PERIPH-1:0]          p_ready_i
);

    localparam int unsigned c_IDX_W = (WINDOW_REGIONS > 1) ? $clog2(WINDOW_REGIONS) : 1;
    localparam int unsigned c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]    c_WIN_BYTES = (ADDR_W + 1)'(WINDOW_REGIONS) << REGION_SHIFT;
    localparam logic [c_IDX_W:0]   c_N_PERIPH  = (c_IDX_W + 1)'(N_PERIPH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   write_q, write_d;
    logic [REGION_SHIFT-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [c_IDX_W-1:0]     idx_q, idx_d;
    logic                   err_q, err_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;

    logic [ADDR_W-1:0]      w_off;
    logic                   w_in_win;
    logic [c_IDX_W-1:0]     w_idx;
    logic                   w_mapped;
    logic                   w_ready;
    logic [DATA_W-1:0]      w_rdata;
    logic [N_PERIPH-1:0]    w_sel_oh;

    // Offset is computed by subtraction so a window ending at the top of the
    // address space never overflows the compare.
    assign w_off     = cpu_addr_i - MMIO_BASE;
    assign w_in_win  = (cpu_addr_i >= MMIO_BASE) && ({1'b0, w_off} < c_WIN_BYTES);
    assign w_idx     = w_off[REGION_SHIFT +: c_IDX_W];
    assign w_mapped  = ({1'b0, w_idx} < c_N_PERIPH);
    assign mem_sel_o = cpu_req_i && !w_in_win;

    assign cpu_rdata_o = rdata_q;
    assign p_write_o   = write_q;
    assign p_addr_o    = addr_q;
    assign p_wdata_o   = wdata_q;

    always_comb begin
        w_ready  = 1'b0;
        w_rdata  = '0;
        w_sel_oh = '0;
        for (int i = 0; i < N_PERIPH; i++) begin
            if (idx_q == c_IDX_W'(i)) begin
                w_ready     = p_ready_i[i];
                w_rdata     = p_rdata_i[i*DATA_W +: DATA_W];
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        cpu_stall_o = 1'b0;
        cpu_done_o  = 1'b0;
        cpu_err_o   = 1'b0;
        p_sel_o     = '0;
        p_enable_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cpu_stall_o = cpu_req_i && w_in_win;
                if (cpu_req_i && w_in_win) begin
                    write_d = cpu_write_i;
                    addr_d  = w_off[REGION_SHIFT-1:0];
                    wdata_d = cpu_wdata_i;
                    idx_d   = w_idx;
                    err_d   = !w_mapped;
                    state_d = w_mapped ? S_SETUP : S_RESP;
                end
            end
            S_SETUP: begin
                cpu_stall_o = 1'b1;
                p_sel_o     = w_sel_oh;
                state_d     = S_ACCESS;
            end
            S_ACCESS: begin
                cpu_stall_o = 1'b1;
                p_sel_o     = w_sel_oh;
                p_enable_o  = 1'b1;
                cnt_d       = cnt_q + c_CNT_W'(1);
                // Ready is checked first so a response on the last allowed
                // cycle completes cleanly instead of timing out.
                if (w_ready) begin
                    if (!write_q) begin
                        rdata_d = w_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == c_CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cpu_done_o = 1'b1;
                cpu_err_o  = err_q;
                cnt_d      = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmio_bus_bridge
// Purpose : Transaction-level model driven bench for mmio_bus_bridge.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_mmio_bus_bridge;

    localparam logic [31:0] c_BASE      = 32'hFFFF0000;
    localparam int          c_TIMEOUT   = 16;
    localparam int          c_WIN_BYTES = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req, cpu_write;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_stall, cpu_done, cpu_err, mem_sel;
    logic [3:0]   p_sel;
    logic         p_enable, p_write;
    logic [2:0]   p_addr;
    logic [31:0]  p_wdata;
    logic [127:0] p_rdata;
    logic [3:0]   p_ready;

    always #5 clk = ~clk;

    mmio_bus_bridge dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req_i   (cpu_req),
        .cpu_write_i (cpu_write),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .cpu_done_o  (cpu_done),
        .cpu_err_o   (cpu_err),
        .mem_sel_o   (mem_sel),
        .p_sel_o     (p_sel),
        .p_enable_o  (p_enable),
        .p_write_o   (p_write),
        .p_addr_o    (p_addr),
        .p_wdata_o   (p_wdata),
        .p_rdata_i   (p_rdata),
        .p_ready_i   (p_ready)
    );

    typedef struct {
        logic        stall, done, err, mem_sel, p_en, chk_p, p_write;
        logic [3:0]  p_sel;
        logic [2:0]  p_addr;
        logic [31:0] p_wdata, rdata;
    } exp_t;

    exp_t        exp_c;
    bit          chk_en = 1'b0;
    int          n_vec = 0, n_err = 0, cyc = 0, t_start = 0;
    int          done_cyc[$];
    logic [31:0] m_rdata;
    bit          use_forced = 1'b0;
    logic [31:0] forced_rd = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.stall = 1'b0; e.done = 1'b0; e.err = 1'b0; e.mem_sel = 1'b0;
        e.p_en = 1'b0; e.chk_p = 1'b0; e.p_write = 1'b0;
        e.p_sel = '0; e.p_addr = '0; e.p_wdata = '0;
        e.rdata = m_rdata;
        return e;
    endfunction

    function automatic int last_lat();
        return (done_cyc.size() > 0) ? done_cyc[$] - t_start : -1000;
    endfunction

    function automatic int last_gap();
        return (done_cyc.size() > 1) ? done_cyc[$] - done_cyc[$-1] : -1000;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("cpu_stall", 32'(cpu_stall), 32'(exp_c.stall));
            check("cpu_done",  32'(cpu_done),  32'(exp_c.done));
            check("cpu_err",   32'(cpu_err),   32'(exp_c.err));
            check("mem_sel",   32'(mem_sel),   32'(exp_c.mem_sel));
            check("p_sel",     32'(p_sel),     32'(exp_c.p_sel));
            check("p_enable",  32'(p_enable),  32'(exp_c.p_en));
            check("cpu_rdata", cpu_rdata,      exp_c.rdata);
            if (exp_c.chk_p) begin
                check("p_write", 32'(p_write), 32'(exp_c.p_write));
                check("p_addr",  32'(p_addr),  32'(exp_c.p_addr));
                check("p_wdata", p_wdata,      exp_c.p_wdata);
            end
            if (cpu_done) done_cyc.push_back(cyc);
        end
    end

    task automatic cycle_start();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Random data on every slice; ready noise everywhere except the bits in hold.
    task automatic set_noise(input logic [3:0] hold, input logic [3:0] force_rdy);
        p_rdata = {$urandom, $urandom, $urandom, $urandom};
        p_ready = (4'($urandom) & ~hold) | force_rdy;
    endtask

    task automatic idle_cycle();
        cycle_start();
        cpu_req   = 1'b0;
        cpu_write = 1'($urandom);
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        set_noise(4'b0, 4'b0);
        exp_c = idle_exp();
    endtask

    // One CPU request held until it is accepted; w = wait states before the
    // peripheral answers (w >= TIMEOUT never answers). rst_at = ACCESS cycle
    // index in which reset is pulsed, or -1.
    task automatic do_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input int w, input int rst_at);
        longint unsigned la;
        bit              in_win, to;
        int              idx, n_acc;
        logic [3:0]      oh;
        logic [31:0]     got;
        exp_t            e;
        la     = 64'(addr);
        in_win = (la >= 64'(c_BASE)) && (la < 64'(c_BASE) + 64'(c_WIN_BYTES));
        got    = '0;
        cycle_start();
        t_start   = cyc;
        cpu_req   = 1'b1;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        if (!in_win) begin
            set_noise(4'b0, 4'b0);
            e = idle_exp();
            e.mem_sel = 1'b1;
            exp_c = e;
            return;
        end
        idx = int'((la - 64'(c_BASE)) >> 3);
        e = idle_exp();
        e.stall = 1'b1;
        if (idx >= 4) begin
            set_noise(4'b0, 4'b0);
            exp_c = e;
            cycle_start();
            set_noise(4'b0, 4'b0);
            e = idle_exp();
            e.done = 1'b1;
            e.err  = 1'b1;
            exp_c = e;
            return;
        end
        oh = 4'b0001 << idx;
        set_noise(oh, 4'b0);
        exp_c = e;
        cycle_start();
        set_noise(oh, 4'b0);
        e.p_sel = oh; e.chk_p = 1'b1; e.p_write = wr; e.p_addr = addr[2:0]; e.p_wdata = wd;
        exp_c = e;
        to    = (w >= c_TIMEOUT);
        n_acc = to ? c_TIMEOUT : w + 1;
        e.p_en = 1'b1;
        for (int j = 0; j < n_acc; j++) begin
            cycle_start();
            if (j == rst_at) begin
                set_noise(oh, 4'b0);
                reset = 1'b1;
                exp_c = e;
                cycle_start();
                reset   = 1'b0;
                cpu_req = 1'b0;
                set_noise(4'b0, 4'b0);
                m_rdata = '0;
                e = idle_exp();
                e.chk_p = 1'b1;
                exp_c = e;
                return;
            end
            set_noise(oh, (j == w) ? oh : 4'b0);
            if (j == w) begin
                if (use_forced) p_rdata[idx*32 +: 32] = forced_rd;
                got = p_rdata[idx*32 +: 32];
            end
            exp_c = e;
        end
        cycle_start();
        set_noise(oh, 4'b0);
        if (!wr) m_rdata = to ? 32'h0 : got;
        e = idle_exp();
        e.done = 1'b1;
        e.err  = to;
        exp_c = e;
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        p_rdata = '0; p_ready = '0; m_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        exp_c = idle_exp();
        exp_c.chk_p = 1'b1;
        chk_en = 1'b1;
        cycle_start();
        reset = 1'b0;
        idle_cycle();

        // Zero-wait load from peripheral 1.
        use_forced = 1'b1; forced_rd = 32'hA5A5_0001;
        do_txn(c_BASE + 32'h08, 1'b0, 32'h0, 0, -1);
        use_forced = 1'b0;
        @(negedge clk); #1;
        check("lit_rd1_rdata", cpu_rdata, 32'hA5A5_0001);
        check("lit_rd1_err", 32'(cpu_err), 32'd0);
        check("lit_rd1_lat", 32'(last_lat()), 32'd3);

        // Store to peripheral 3 offset 4 with three wait states.
        do_txn(c_BASE + 32'h1C, 1'b1, 32'h1234, 3, -1);
        @(negedge clk); #1;
        check("lit_wr3_rdata", cpu_rdata, 32'hA5A5_0001);
        check("lit_wr3_lat", 32'(last_lat()), 32'd6);

        // Timeout, then ready on the last allowed ACCESS cycle.
        do_txn(c_BASE, 1'b0, 32'h0, c_TIMEOUT, -1);
        @(negedge clk); #1;
        check("lit_to_err", 32'(cpu_err), 32'd1);
        check("lit_to_rdata", cpu_rdata, 32'd0);
        check("lit_to_lat", 32'(last_lat()), 32'd18);
        do_txn(c_BASE, 1'b0, 32'h0, c_TIMEOUT - 1, -1);
        @(negedge clk); #1;
        check("lit_last_err", 32'(cpu_err), 32'd0);
        check("lit_last_lat", 32'(last_lat()), 32'd18);

        // Unmapped region and out-of-window address.
        do_txn(c_BASE + 32'h28, 1'b0, 32'h0, 0, -1);
        @(negedge clk); #1;
        check("lit_unm_err", 32'(cpu_err), 32'd1);
        check("lit_unm_lat", 32'(last_lat()), 32'd1);
        do_txn(32'h0000_1000, 1'b0, 32'h0, 0, -1);
        @(negedge clk); #1;
        check("lit_mem_sel", 32'(mem_sel), 32'd1);
        check("lit_mem_stall", 32'(cpu_stall), 32'd0);

        // Peripheral 1 with waits (noise on other ready bits), reset mid-access.
        do_txn(c_BASE + 32'h0C, 1'b0, 32'h0, 2, -1);
        do_txn(c_BASE + 32'h08, 1'b0, 32'h0, 5, 1);
        idle_cycle();

        // Back-to-back loads.
        do_txn(c_BASE + 32'h00, 1'b0, 32'h0, 0, -1);
        do_txn(c_BASE + 32'h08, 1'b0, 32'h0, 0, -1);
        @(negedge clk); #1;
        check("lit_b2b_gap", 32'(last_gap()), 32'd4);

        for (int k = 0; k < 300; k++) begin
            int          kind, w, rst_at, n_idle;
            logic        wr;
            logic [31:0] a;
            kind = int'($urandom_range(0, 9));
            if (kind < 2) begin
                case ($urandom_range(0, 3))
                    0:       a = $urandom & 32'h7FFF_FFFF;
                    1:       a = c_BASE - 32'd1;
                    2:       a = c_BASE + 32'd64;
                    default: a = 32'hFFFF_FFFF;
                endcase
            end else begin
                a = c_BASE + 32'($urandom_range(0, 63));
            end
            wr = 1'($urandom);
            if (wr) w = int'($urandom_range(0, c_TIMEOUT - 1));
            else if ($urandom_range(0, 4) == 0) w = int'($urandom_range(c_TIMEOUT - 2, c_TIMEOUT + 1));
            else w = int'($urandom_range(0, 6));
            rst_at = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 3)) : -1;
            do_txn(a, wr, $urandom, w, rst_at);
            n_idle = int'($urandom_range(0, 2));
            for (int m = 0; m < n_idle; m++) idle_cycle();
        end

        idle_cycle();
        idle_cycle();
        @(negedge clk); #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
